// File: rtl/sample_scheduler.sv
// sample_scheduler: paces stimulus writes and response reads at SAMPLE_FREQ
// derived from clk by a phase accumulator, with a programmable read latency.
// Ports: clk/rst_n; start/stop run control; num_samples, dut_latency latched
// on start; stim_valid/stim_ready stimulus handshake; write_en/read_en
// strobes; sample_idx, busy, done status; underrun/overrun sticky flags.
module sample_scheduler #(
  parameter int DUT_CLK_FREQ = 100_000_000,
  parameter int SAMPLE_FREQ  = 1_000_000,
  parameter int ACC_W        = 32,
  parameter int CNT_W        = 16,
  parameter int LAT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [LAT_W-1:0] dut_latency,
  input  logic             stim_valid,
  output logic             stim_ready,
  output logic             write_en,
  output logic             read_en,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             overrun
);

  if (SAMPLE_FREQ > DUT_CLK_FREQ) begin : g_rate_chk
    $error("SAMPLE_FREQ must not exceed DUT_CLK_FREQ");
  end

  if ((longint'(DUT_CLK_FREQ) + longint'(SAMPLE_FREQ))
      >= (longint'(1) << ACC_W)) begin : g_acc_chk
    $error("ACC_W too narrow for DUT_CLK_FREQ + SAMPLE_FREQ");
  end

  localparam int AW1 = ACC_W + 1;
  localparam logic [ACC_W:0] SF_C  = AW1'(SAMPLE_FREQ);
  localparam logic [ACC_W:0] DCF_C = AW1'(DUT_CLK_FREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LAT,
    S_READ,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   ns_q, ns_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               und_q, und_d;
  logic               ovr_q, ovr_d;

  logic [ACC_W:0]     sum;
  logic               tick;
  logic               run;
  logic               wr, rd, rdy, dn;

  assign sum  = {1'b0, acc_q} + SF_C;
  assign tick = (sum >= DCF_C);
  assign run  = (state_q == S_ARMED) ||
                (state_q == S_LAT)   ||
                (state_q == S_READ);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ns_d    = ns_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    und_d   = und_q;
    ovr_d   = ovr_q;
    wr      = 1'b0;
    rd      = 1'b0;
    rdy     = 1'b0;
    dn      = 1'b0;

    if (run) begin
      acc_d = tick ? ACC_W'(sum - DCF_C) : ACC_W'(sum);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          ns_d  = num_samples;
          lat_d = dut_latency;
          acc_d = '0;
          if (num_samples != '0) begin
            idx_d   = '0;
            und_d   = 1'b0;
            ovr_d   = 1'b0;
            state_d = S_ARMED;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (stim_valid) begin
            wr  = 1'b1;
            rdy = 1'b1;
            // LAT lasts dut_latency cycles; zero skips straight to READ
            if (lat_q == '0) begin
              state_d = S_READ;
            end else begin
              cnt_d   = lat_q - LAT_W'(1);
              state_d = S_LAT;
            end
          end else begin
            und_d = 1'b1;
          end
        end
      end
      S_LAT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          if (tick) ovr_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
      end
      S_READ: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          rd = 1'b1;
          if (tick) ovr_d = 1'b1;
          if (idx_q == ns_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = S_ARMED;
          end
        end
      end
      S_DONE: begin
        dn      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      ns_q    <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
      und_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ns_q    <= ns_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      und_q   <= und_d;
      ovr_q   <= ovr_d;
    end
  end

  assign stim_ready = rdy;
  assign write_en   = wr;
  assign read_en    = rd;
  assign sample_idx = idx_q;
  assign busy       = run;
  assign done       = dn;
  assign underrun   = und_q;
  assign overrun    = ovr_q;

endmodule
